// File: rtl/data_memory_ws.sv
// Big-endian byte-addressed data memory with byte/half/word access and sign/zero-extended loads.
// Latency: Ready pulses WAIT_STATES+1 cycles after the cycle Req is presented; one access per WAIT_STATES+1 cycles.
// Backpressure: Req is only accepted in IDLE or DONE; the master holds Req until Ready, Req during BUSY is ignored.
`timescale 1ns/1ps
module data_memory_ws #(
  parameter int    DEPTH_BYTES = 64,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = "dm.txt"
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        DataMemRW,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic        Ready,
  output logic [31:0] DataOut,
  output logic        Fault
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;

  // Storage; never cleared by reset so an image survives a core reset.
  logic [7:0]  mem [DEPTH_BYTES];

  // Access captured at accept time.
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        enter_done;

  // Access being resolved this cycle: latched copy while BUSY, live inputs otherwise
  // (with zero wait states the load is resolved on the very edge that accepts it).
  logic [31:0] cur_addr;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic        cur_rw;
  logic        cur_fault;

  // Store retiring at the end of this cycle, forwarded into a same-edge load.
  logic          wr_commit;
  logic [AW-1:0] wr_base;
  int            wr_n;

  logic [AW-1:0] ra   [4];
  logic [AW-1:0] off  [4];
  logic [4:0]    sh   [4];
  logic [7:0]    lane [4];
  logic [31:0]   rdat;

  // Misaligned, reserved size, or any byte address at/after the end of storage.
  function automatic logic access_fault(input logic [31:0] a, input logic [1:0] sz);
    access_fault = (sz == 2'b11)
                || (sz == 2'b01 && a[0])
                || (sz == 2'b10 && a[1:0] != 2'b00)
                || (a >= DEPTH_W);
  endfunction

  // Number of bytes touched by an access of the given size.
  function automatic int access_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   access_bytes = 1;
      2'b01:   access_bytes = 2;
      2'b10:   access_bytes = 4;
      default: access_bytes = 0;
    endcase
  endfunction

  assign accept = Req && (state_q == IDLE || state_q == DONE);
  assign Ready  = (state_q == DONE);

  // Next-state logic: accept from IDLE/DONE, count wait states in BUSY.
  always_comb begin
    state_d    = state_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Req) begin
          if (WAIT_STATES > 0) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load datapath: gather four big-endian lanes, forward any retiring store, extend.
  always_comb begin
    cur_addr  = (state_q == BUSY) ? addr_q : DAddr;
    cur_size  = (state_q == BUSY) ? size_q : Size;
    cur_uns   = (state_q == BUSY) ? uns_q  : Unsigned;
    cur_rw    = (state_q == BUSY) ? rw_q   : DataMemRW;
    cur_fault = access_fault(cur_addr, cur_size);

    wr_commit = (state_q == DONE) && rw_q && !access_fault(addr_q, size_q);
    wr_base   = addr_q[AW-1:0];
    wr_n      = access_bytes(size_q);

    for (int k = 0; k < 4; k++) begin
      ra[k]   = cur_addr[AW-1:0] + AW'(k);
      off[k]  = ra[k] - wr_base;
      sh[k]   = 5'((wr_n - 1 - int'(off[k])) * 8);
      lane[k] = mem[ra[k]];
      if (wr_commit && int'(off[k]) < wr_n) begin
        lane[k] = 8'(wdat_q >> sh[k]);
      end
    end

    case (cur_size)
      2'b00:   rdat = cur_uns ? {24'd0, lane[0]} : {{24{lane[0][7]}}, lane[0]};
      2'b01:   rdat = cur_uns ? {16'd0, lane[0], lane[1]}
                              : {{16{lane[0][7]}}, lane[0], lane[1]};
      2'b10:   rdat = {lane[0], lane[1], lane[2], lane[3]};
      default: rdat = 32'd0;
    endcase

    if (cur_fault || cur_rw) begin
      rdat = 32'd0;
    end
  end

  // Control and result registers; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      DataOut <= 32'd0;
      Fault   <= 1'b0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == BUSY && state_d == BUSY) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= 4'd0;
      end

      if (accept) begin
        addr_q <= DAddr;
        wdat_q <= DataIn;
        rw_q   <= DataMemRW;
        size_q <= Size;
        uns_q  <= Unsigned;
      end

      if (enter_done) begin
        DataOut <= rdat;
        Fault   <= cur_fault;
      end
    end
  end

  // Store commit at the end of DONE; MSB of the store lands at the lowest address.
  always_ff @(posedge CLK) begin
    if (Reset_n && wr_commit) begin
      case (size_q)
        2'b10: begin
          mem[wr_base]           <= wdat_q[31:24];
          mem[wr_base + AW'(1)]  <= wdat_q[23:16];
          mem[wr_base + AW'(2)]  <= wdat_q[15:8];
          mem[wr_base + AW'(3)]  <= wdat_q[7:0];
        end
        2'b01: begin
          mem[wr_base]           <= wdat_q[15:8];
          mem[wr_base + AW'(1)]  <= wdat_q[7:0];
        end
        default: begin
          mem[wr_base]           <= wdat_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: three instances at 0, 1 and 3 wait states.
// Latency: measured from the cycle Req is presented to the cycle Ready is seen.
// Backpressure: Req is held only through the accepting edge except in back-to-back runs.
`timescale 1ns/1ps
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] din;

  logic        req0, req1, req3;
  logic        rdy0, rdy1, rdy3;
  logic [31:0] dout0, dout1, dout3;
  logic        flt0, flt1, flt3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory_ws #(.DEPTH_BYTES(64), .WAIT_STATES(0), .INIT_FILE("")) u0 (
    .CLK(clk), .Reset_n(rst_n), .Req(req0), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .Ready(rdy0), .DataOut(dout0), .Fault(flt0));

  data_memory_ws #(.DEPTH_BYTES(64), .WAIT_STATES(1), .INIT_FILE("")) u1 (
    .CLK(clk), .Reset_n(rst_n), .Req(req1), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .Ready(rdy1), .DataOut(dout1), .Fault(flt1));

  data_memory_ws #(.DEPTH_BYTES(64), .WAIT_STATES(3), .INIT_FILE("")) u3 (
    .CLK(clk), .Reset_n(rst_n), .Req(req3), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .Ready(rdy3), .DataOut(dout3), .Fault(flt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int u, input logic v);
    case (u)
      0:       req0 = v;
      1:       req1 = v;
      default: req3 = v;
    endcase
  endtask

  function automatic logic rdy_of(input int u);
    case (u)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int u);
    case (u)
      0:       return dout0;
      1:       return dout1;
      default: return dout3;
    endcase
  endfunction

  function automatic logic flt_of(input int u);
    case (u)
      0:       return flt0;
      1:       return flt1;
      default: return flt3;
    endcase
  endfunction

  // One access on instance u; returns result and cycles from Req cycle to Ready (0 = timeout).
  task automatic acc(input int u, input logic wr, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] o_dat, output logic o_flt, output int lat);
    logic got;
    got   = 1'b0;
    lat   = 0;
    o_dat = 32'hx;
    o_flt = 1'bx;
    @(negedge clk);
    rw = wr; size = sz; uns = un; addr = a; din = d;
    set_req(u, 1'b1);
    @(posedge clk);
    #1;
    set_req(u, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (!got) begin
        @(negedge clk);
        if (rdy_of(u)) begin
          got   = 1'b1;
          lat   = i;
          o_dat = dout_of(u);
          o_flt = flt_of(u);
        end
      end
    end
  endtask

  task automatic chk_acc(input string tag, input int u, input logic wr, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_dat, input logic exp_flt);
    logic [31:0] o_dat;
    logic        o_flt;
    int          lat;
    int          exp_lat;
    exp_lat = (u == 0) ? 1 : (u == 1) ? 2 : 4;
    acc(u, wr, sz, un, a, d, o_dat, o_flt, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".dat"}, o_dat, exp_dat);
    chk({tag, ".flt"}, {31'd0, o_flt}, {31'd0, exp_flt});
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];
  logic [31:0] bytes_exp [4];

  initial begin
    rst_n = 1'b0; rw = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; din = '0;
    req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", {31'd0, rdy1}, 32'd0);
    chk("rst.dat", dout1, 32'd0);
    chk("rst.flt", {31'd0, flt1}, 32'd0);
    chk("rst.rdy0", {31'd0, rdy0}, 32'd0);
    rst_n = 1'b1;

    // Word store then load, one wait state.
    chk_acc("t1.wr",  1, 1'b1, 2'b10, 1'b0, 32'd0, 32'h11223344, 32'h0, 1'b0);
    chk_acc("t1.rd",  1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0);
    bytes_exp[0] = 32'h11; bytes_exp[1] = 32'h22; bytes_exp[2] = 32'h33; bytes_exp[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      chk_acc($sformatf("t1.b%0d", i), 1, 1'b0, 2'b00, 1'b1, 32'(i), 32'h0, bytes_exp[i], 1'b0);
    end

    // Byte store into a known word; sign and zero extension.
    chk_acc("t2.wr4",  1, 1'b1, 2'b10, 1'b0, 32'd4, 32'hA0A1A2A3, 32'h0, 1'b0);
    chk_acc("t2.wrb",  1, 1'b1, 2'b00, 1'b0, 32'd5, 32'h12345680, 32'h0, 1'b0);
    chk_acc("t2.rbs",  1, 1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 32'hFFFFFF80, 1'b0);
    chk_acc("t2.rbu",  1, 1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 32'h00000080, 1'b0);
    chk_acc("t2.rw4",  1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'hA080A2A3, 1'b0);

    // Halfword store; misaligned and out-of-range faults leave memory alone.
    chk_acc("t3.wrh",  1, 1'b1, 2'b01, 1'b0, 32'd6, 32'hCAFEBEEF, 32'h0, 1'b0);
    chk_acc("t3.rhs",  1, 1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 32'hFFFFBEEF, 1'b0);
    chk_acc("t3.rhu",  1, 1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 32'h0000BEEF, 1'b0);
    chk_acc("t3.h7",   1, 1'b0, 2'b01, 1'b0, 32'd7, 32'h0, 32'h0, 1'b1);
    chk_acc("t3.w2",   1, 1'b0, 2'b10, 1'b0, 32'd2, 32'h0, 32'h0, 1'b1);
    chk_acc("t3.w64",  1, 1'b0, 2'b10, 1'b0, 32'd64, 32'h0, 32'h0, 1'b1);
    chk_acc("t3.ww2",  1, 1'b1, 2'b10, 1'b0, 32'd2, 32'hDEADDEAD, 32'h0, 1'b1);
    chk_acc("t3.wh5",  1, 1'b1, 2'b01, 1'b0, 32'd5, 32'h0000DEAD, 32'h0, 1'b1);
    chk_acc("t3.ww64", 1, 1'b1, 2'b10, 1'b0, 32'd64, 32'hDEADDEAD, 32'h0, 1'b1);
    chk_acc("t3.rb0",  1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0);
    chk_acc("t3.rb4",  1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'hA080BEEF, 1'b0);
    chk_acc("t3.w60",  1, 1'b1, 2'b10, 1'b0, 32'd60, 32'h8BADF00D, 32'h0, 1'b0);
    chk_acc("t3.r63",  1, 1'b0, 2'b00, 1'b1, 32'd63, 32'h0, 32'h0000000D, 1'b0);

    // Zero wait states: preload, then four back-to-back loads with Req held high.
    b2b_addr[0] = 32'd0;  b2b_data[0] = 32'h01020304;
    b2b_addr[1] = 32'd4;  b2b_data[1] = 32'h05060708;
    b2b_addr[2] = 32'd8;  b2b_data[2] = 32'h090A0B0C;
    b2b_addr[3] = 32'd12; b2b_data[3] = 32'h0D0E0F10;
    for (int i = 0; i < 4; i++) begin
      chk_acc($sformatf("t4.wr%0d", i), 0, 1'b1, 2'b10, 1'b0, b2b_addr[i], b2b_data[i], 32'h0, 1'b0);
    end
    @(negedge clk);
    rw = 1'b0; size = 2'b10; uns = 1'b0; addr = b2b_addr[0]; din = '0;
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4.rdy%0d", i), {31'd0, rdy0}, 32'd1);
      chk($sformatf("t4.dat%0d", i), dout0, b2b_data[i]);
      if (i < 3) addr = b2b_addr[i + 1];
      else       req0 = 1'b0;
    end
    @(negedge clk);
    chk("t4.idle", {31'd0, rdy0}, 32'd0);

    // Reset while a store waits in BUSY: no Ready, no write.
    chk_acc("t5.pre", 1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0);
    @(negedge clk);
    rw = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'd0; din = 32'h55667788;
    req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("t5.busy", {31'd0, rdy1}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5.rdy", {31'd0, rdy1}, 32'd0);
    chk("t5.dat", dout1, 32'd0);
    chk("t5.flt", {31'd0, flt1}, 32'd0);
    rst_n = 1'b1;
    chk_acc("t5.rd", 1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0);

    // Reserved size faults; three wait states give Ready four cycles on.
    chk_acc("t6.r11",  1, 1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1);
    chk_acc("t6.w11",  1, 1'b1, 2'b11, 1'b0, 32'd0, 32'hFFFFFFFF, 32'h0, 1'b1);
    chk_acc("t6.rchk", 1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0);
    chk_acc("t6.w3",   3, 1'b1, 2'b10, 1'b0, 32'd8, 32'hCAFEF00D, 32'h0, 1'b0);
    chk_acc("t6.r3",   3, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'hCAFEF00D, 1'b0);
    chk_acc("t6.h3",   3, 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 32'hFFFFF00D, 1'b0);
    chk_acc("t6.s3",   3, 1'b0, 2'b11, 1'b0, 32'd8, 32'h0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
